// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Initiator side of the ALU operand/result interface. Tagged requests are
//   buffered in a DEPTH-entry FIFO; the FIFO head drives the combinational
//   ALU directly, and its result is captured into a response register that
//   is returned with the request tag over a valid/ready channel.
//
// Ports
//   clock, reset          : single clock, synchronous active-high reset
//   req_*                 : request channel (valid/ready), op + 3 operands,
//                           immediate and an opaque tag
//   alu_*                 : operation/operands to the ALU, output_0 back
//   resp_*                : response channel (valid/ready), result + tag
//   issued_count          : results captured since reset (wraps at 16 bits)
//   occupancy             : current FIFO entry count
module alu_op_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [4:0]                 req_op,
    input  logic [63:0]                req_in0,
    input  logic [63:0]                req_in1,
    input  logic [63:0]                req_in2,
    input  logic [16:0]                req_imm,
    input  logic [TAG_W-1:0]           req_tag,
    output logic [4:0]                 alu_operation,
    output logic [63:0]                alu_inputs_0,
    output logic [63:0]                alu_inputs_1,
    output logic [63:0]                alu_inputs_2,
    output logic [16:0]                alu_immediate,
    input  logic [63:0]                alu_output_0,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [63:0]                resp_data,
    output logic [TAG_W-1:0]           resp_tag,
    output logic [15:0]                issued_count,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [4:0]       op;
        logic [63:0]      in0;
        logic [63:0]      in1;
        logic [63:0]      in2;
        logic [16:0]      imm;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             issue;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign req_ready = !full;
    assign occupancy = count;

    // No bypass when full: a pop in the same cycle does not free a slot
    // for the incoming request until the next cycle.
    assign push  = req_valid && !full;
    // The response register can take a new result when it is empty or is
    // being drained this cycle, giving one result per cycle when streaming.
    assign issue = !empty && (!resp_valid || resp_ready);

    assign head = mem[rptr];

    always_comb begin
        alu_operation = '0;
        alu_inputs_0  = '0;
        alu_inputs_1  = '0;
        alu_inputs_2  = '0;
        alu_immediate = '0;
        if (!empty) begin
            alu_operation = head.op;
            alu_inputs_0  = head.in0;
            alu_inputs_1  = head.in1;
            alu_inputs_2  = head.in2;
            alu_immediate = head.imm;
        end
    end

    // Storage is left unreset; entries are only visible through the
    // pointers and count, which are reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr] <= '{op:  req_op,  in0: req_in0, in1: req_in1,
                           in2: req_in2, imm: req_imm, tag: req_tag};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_tag     <= '0;
            issued_count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (issue) begin
                rptr         <= rptr + 1'b1;
                resp_data    <= alu_output_0;
                resp_tag     <= head.tag;
                issued_count <= issued_count + 16'd1;
            end

            unique case ({push, issue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (issue) begin
                resp_valid <= 1'b1;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule
